// File: rtl/ami_channel_scheduler.sv
// Weighted round-robin arbiter sharing one AMI channel among app streams.
// Optional per-app grant counters are built when AMI_SCHED_STATS_EN is defined.
module ami_channel_scheduler #(
  parameter int NUM_APPS        = 4,
  parameter int APP_BITS        = 2,
  parameter int WEIGHT_BITS     = 4,
  parameter int CREDIT_BITS     = 6,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_APPS-1:0]             app_enable,
  input  logic [NUM_APPS-1:0]             req_valid,
  output logic [NUM_APPS-1:0]             req_grant,
  output logic                            out_valid,
  output logic [APP_BITS-1:0]             out_app,
  input  logic                            out_ready,
  input  logic                            resp_done,
  input  logic [APP_BITS-1:0]             resp_app,
  input  logic                            cfg_wr,
  input  logic [APP_BITS-1:0]             cfg_app,
  input  logic [WEIGHT_BITS-1:0]          cfg_weight,
  output logic                            credit_err,
  output logic [NUM_APPS*CREDIT_BITS-1:0] outstanding_flat,
  input  logic [APP_BITS-1:0]             stat_sel,
  output logic [31:0]                     stat_count
);

  localparam logic [CREDIT_BITS-1:0] CAP =
    CREDIT_BITS'(MAX_OUTSTANDING);

  logic [APP_BITS-1:0]    ptr;
  logic [WEIGHT_BITS-1:0] quota_left;
  logic [CREDIT_BITS-1:0] out_cnt [NUM_APPS];
  logic [WEIGHT_BITS-1:0] weight  [NUM_APPS];

  logic [NUM_APPS-1:0] elig;
  logic [NUM_APPS-1:0] resp_hit;
  logic [NUM_APPS-1:0] cnt_zero;
  logic                cont;
  logic                found;
  logic [APP_BITS-1:0] winner;
  logic [APP_BITS-1:0] idx;
  logic                accept;

  // Per-app eligibility and response decode
  always_comb begin
    elig     = '0;
    resp_hit = '0;
    cnt_zero = '0;
    for (int i = 0; i < NUM_APPS; i++) begin
      elig[i] = app_enable[i] & req_valid[i]
              & (out_cnt[i] < CAP);
      resp_hit[i] = resp_done
                  & (resp_app == APP_BITS'(i));
      cnt_zero[i] = (out_cnt[i] == '0);
    end
  end

  // Winner: keep the owner while quota lasts, else scan from ptr+1
  always_comb begin
    cont   = elig[ptr] & (quota_left != '0);
    found  = cont;
    winner = ptr;
    idx    = '0;
    if (!cont) begin
      // descending scan so the nearest index after ptr wins
      for (int k = NUM_APPS; k >= 1; k--) begin
        idx = APP_BITS'((int'(ptr) + k) % NUM_APPS);
        if (elig[idx]) begin
          found  = 1'b1;
          winner = idx;
        end
      end
    end
  end

  // Outputs are forced quiet while reset is held
  always_comb begin
    out_valid = found & ~rst;
    out_app   = out_valid ? winner : '0;
    accept    = out_valid & out_ready;
    req_grant = accept ? (NUM_APPS'(1) << winner) : '0;
  end

  // Turn pointer and remaining quantum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= APP_BITS'(NUM_APPS - 1);
      quota_left <= '0;
    end else if (accept) begin
      if (cont) begin
        quota_left <= quota_left - 1'b1;
      end else begin
        ptr        <= winner;
        quota_left <= weight[winner] - 1'b1;
      end
    end
  end

  // Quantum table; a zero weight still grants once per turn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_APPS; i++)
        weight[i] <= WEIGHT_BITS'(1);
    end else if (cfg_wr) begin
      weight[cfg_app] <= (cfg_weight == '0)
                       ? WEIGHT_BITS'(1) : cfg_weight;
    end
  end

  // Outstanding credits and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_APPS; i++)
        out_cnt[i] <= '0;
      credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_APPS; i++) begin
        if (req_grant[i] & ~resp_hit[i])
          out_cnt[i] <= out_cnt[i] + 1'b1;
        else if (resp_hit[i] & ~req_grant[i]
                 & ~cnt_zero[i])
          out_cnt[i] <= out_cnt[i] - 1'b1;
      end
      if (|(resp_hit & ~req_grant & cnt_zero))
        credit_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_APPS; g++) begin : g_flat
    assign outstanding_flat[g*CREDIT_BITS +: CREDIT_BITS]
      = out_cnt[g];
  end

`ifdef AMI_SCHED_STATS_EN
  logic [31:0] stat_cnt [NUM_APPS];

  // Free-running grant counters, wrap at 2**32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_APPS; i++)
        stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_APPS; i++)
        if (req_grant[i])
          stat_cnt[i] <= stat_cnt[i] + 32'd1;
    end
  end

  assign stat_count = stat_cnt[stat_sel];
`else
  logic unused_stat_sel;

  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_ami_channel_scheduler.sv
// Scoreboard bench for ami_channel_scheduler.
// A rule-level model predicts each cycle; a monitor compares.
module tb_ami_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  app_enable = '0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_grant;
  logic        out_valid;
  logic [1:0]  out_app;
  logic        out_ready = 1'b0;
  logic        resp_done = 1'b0;
  logic [1:0]  resp_app = '0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_app = '0;
  logic [3:0]  cfg_weight = '0;
  logic        credit_err;
  logic [23:0] outstanding_flat;
  logic [1:0]  stat_sel = '0;
  logic [31:0] stat_count;

  ami_channel_scheduler dut (
    .clk(clk), .rst(rst),
    .app_enable(app_enable), .req_valid(req_valid),
    .req_grant(req_grant), .out_valid(out_valid),
    .out_app(out_app), .out_ready(out_ready),
    .resp_done(resp_done), .resp_app(resp_app),
    .cfg_wr(cfg_wr), .cfg_app(cfg_app),
    .cfg_weight(cfg_weight), .credit_err(credit_err),
    .outstanding_flat(outstanding_flat),
    .stat_sel(stat_sel), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ov;
    logic [1:0]  app;
    logic [3:0]  gnt;
    logic [23:0] outs;
    logic        err;
    logic [31:0] stat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int          m_ptr, m_quota, m_err;
  int          m_cnt [4];
  int          m_wt  [4];
  int unsigned m_stat[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 3; m_quota = 0; m_err = 0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_wt[i] = 1; m_stat[i] = 0;
    end
  endtask

  function automatic bit elig(input int i);
    return app_enable[i] && req_valid[i] && m_cnt[i] < 32;
  endfunction

  // One clock cycle: drive, predict, push, advance model
  task automatic step(input logic [3:0] en,
                      input logic [3:0] vld,
                      input logic rdy,
                      input logic rd, input logic [1:0] ra,
                      input logic cw, input logic [1:0] ca,
                      input logic [3:0] wt);
    exp_t e;
    int w;
    bit cont;
    @(negedge clk);
    app_enable = en; req_valid = vld; out_ready = rdy;
    resp_done = rd; resp_app = ra;
    cfg_wr = cw; cfg_app = ca; cfg_weight = wt;
    stat_sel = 2'($urandom_range(0, 3));
    for (int i = 0; i < 4; i++)
      e.outs[i*6 +: 6] = 6'(m_cnt[i]);
    e.err = m_err[0];
`ifdef AMI_SCHED_STATS_EN
    e.stat = m_stat[stat_sel];
`else
    e.stat = 32'd0;
`endif
    w = -1;
    cont = elig(m_ptr) && m_quota > 0;
    if (cont) w = m_ptr;
    else
      for (int k = 1; k <= 4 && w < 0; k++)
        if (elig((m_ptr + k) % 4)) w = (m_ptr + k) % 4;
    e.ov  = (w >= 0);
    e.app = (w >= 0) ? 2'(w) : 2'd0;
    e.gnt = (w >= 0 && rdy) ? 4'(1 << w) : 4'd0;
    q.push_back(e);
    if (w >= 0 && rdy) begin
      if (cont) m_quota--;
      else begin m_ptr = w; m_quota = m_wt[w] - 1; end
      m_stat[w]++;
    end
    for (int i = 0; i < 4; i++) begin
      bit inc, dec;
      inc = e.gnt[i];
      dec = rd && ra == 2'(i);
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1;
        else m_cnt[i]--;
      end
    end
    if (cw) m_wt[ca] = (wt == 0) ? 1 : int'(wt);
  endtask

  // Monitor: compare the DUT against each queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid", 32'(out_valid), 32'(e.ov));
        chk("out_app", 32'(out_app), 32'(e.app));
        chk("req_grant", 32'(req_grant), 32'(e.gnt));
        chk("outstanding", 32'(outstanding_flat),
            32'(e.outs));
        chk("credit_err", 32'(credit_err), 32'(e.err));
        chk("stat_count", stat_count, e.stat);
      end
    end
  end

  task automatic check_quiet(input string tag);
    chk({tag, "_grant"}, 32'(req_grant), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_app"}, 32'(out_app), 32'd0);
    chk({tag, "_outs"}, 32'(outstanding_flat), 32'd0);
    chk({tag, "_err"}, 32'(credit_err), 32'd0);
    chk({tag, "_stat"}, stat_count, 32'd0);
  endtask

  task automatic release_rst();
    app_enable = '0; req_valid = '0; out_ready = 1'b0;
    resp_done = 1'b0; cfg_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_step();
    logic [3:0] en;
    en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
    step(en, 4'($urandom), $urandom_range(0, 3) != 0,
         1'($urandom), 2'($urandom),
         $urandom_range(0, 15) == 0, 2'($urandom),
         4'($urandom));
  endtask

  initial begin
    model_reset();
    app_enable = 4'hF; req_valid = 4'hF; out_ready = 1'b1;
    #1;
    check_quiet("reset");
    release_rst();

    // round robin with unit weights
    repeat (12) step(4'hF, 4'hF, 1, 0, 0, 0, 0, 0);
    // weights {3,1,1,1}
    step(4'hF, 4'h0, 1, 0, 0, 1, 0, 4'd3);
    repeat (16) step(4'hF, 4'hF, 1, 0, 0, 0, 0, 0);
    // stall then resume
    repeat (5) step(4'hF, 4'hF, 0, 0, 0, 0, 0, 0);
    repeat (3) step(4'hF, 4'hF, 1, 0, 0, 0, 0, 0);
    // zero weight stored as one
    step(4'hF, 4'h0, 1, 0, 0, 1, 0, 4'd0);
    // app 2 alone up to the cap, then one credit back
    repeat (40) step(4'hF, 4'h4, 1, 0, 0, 0, 0, 0);
    step(4'hF, 4'h4, 1, 1, 2'd2, 0, 0, 0);
    repeat (3) step(4'hF, 4'h4, 1, 0, 0, 0, 0, 0);
    // drain app 1, underflow it, then grant+resp same cycle
    while (m_cnt[1] > 0) step(4'hF, 4'h0, 1, 1, 2'd1, 0, 0, 0);
    step(4'hF, 4'h0, 1, 1, 2'd1, 0, 0, 0);
    repeat (2) step(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    step(4'hF, 4'h2, 1, 1, 2'd1, 0, 0, 0);
    step(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    // ten grants to app 3
    repeat (10) step(4'hF, 4'h8, 1, 0, 0, 0, 0, 0);
    repeat (4) step(4'hF, 4'h0, 1, 0, 0, 0, 0, 0);
    // randomized traffic
    repeat (600) rand_step();

    // asynchronous reset in the middle of a burst
    step(4'hF, 4'hF, 1, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    model_reset();
    release_rst();
    repeat (200) rand_step();

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
